// File: rtl/bsg_fma_mul_sequencer.sv
// Sequences the shared 24x24+48 FMA datapath: a 32x32 multiply is split into up to
// four carry-chained passes, and a fused multiply-add goes through as a single pass.
module bsg_fma_mul_sequencer #(
  parameter bit skip_zero_high_p = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_i,
  output logic        ready_o,
  input  logic        opcode_i,
  input  logic [31:0] opA_i,
  input  logic [31:0] opB_i,
  input  logic [47:0] opC_i,
  output logic        dp_v_o,
  output logic [23:0] dp_a_o,
  output logic [23:0] dp_b_o,
  output logic [47:0] dp_c_o,
  input  logic        dp_v_i,
  input  logic [47:0] dp_res_i,
  output logic        v_o,
  output logic [63:0] res_o,
  output logic        type_o,
  input  logic        yumi_i,
  output logic [1:0]  state_dbg
);

  // Handshakes: a request moves on v_i & ready_o at a rising edge; a result leaves
  // on v_o & yumi_i at a rising edge; dp_v_o is a one-cycle strobe with no stall.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e      state, next_state;
  logic        op_r;
  logic [31:0] a_r, b_r;
  logic [47:0] c_r;
  logic [47:0] carry_r;
  logic [63:0] res_r;
  logic [1:0]  pass_r;
  logic        last_pass;
  logic        high_zero;

  assign high_zero = (a_r[31:24] == 8'd0) && (b_r[31:24] == 8'd0);
  assign last_pass = op_r || (pass_r == 2'd3) ||
                     ((pass_r == 2'd0) && skip_zero_high_p && high_zero);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_o    = 1'b0;
    dp_v_o     = 1'b0;
    v_o        = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) next_state = ISSUE;
      end
      ISSUE: begin
        dp_v_o     = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (dp_v_i) next_state = last_pass ? DONE : ISSUE;
      end
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Pass operands come only from latched request state and the running carry.
  always_comb begin
    dp_a_o = a_r[23:0];
    dp_b_o = b_r[23:0];
    dp_c_o = op_r ? c_r : 48'd0;
    case (pass_r)
      2'd1: begin
        dp_a_o = {16'd0, a_r[31:24]};
        dp_b_o = b_r[23:0];
        dp_c_o = carry_r;
      end
      2'd2: begin
        dp_a_o = a_r[23:0];
        dp_b_o = {16'd0, b_r[31:24]};
        dp_c_o = carry_r;
      end
      2'd3: begin
        dp_a_o = {16'd0, a_r[31:24]};
        dp_b_o = {16'd0, b_r[31:24]};
        dp_c_o = carry_r;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      op_r    <= 1'b0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      c_r     <= 48'd0;
      carry_r <= 48'd0;
      res_r   <= 64'd0;
      pass_r  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (v_i) begin
            op_r    <= opcode_i;
            a_r     <= opA_i;
            b_r     <= opB_i;
            c_r     <= opC_i;
            carry_r <= 48'd0;
            res_r   <= 64'd0;
            pass_r  <= 2'd0;
          end
        end
        WAIT: begin
          if (dp_v_i) begin
            case (pass_r)
              2'd0: begin
                // A single-pass result is the whole 48-bit sum, zero-extended.
                if (last_pass) res_r <= {16'd0, dp_res_i};
                else           res_r[23:0] <= dp_res_i[23:0];
                carry_r <= {24'd0, dp_res_i[47:24]};
              end
              2'd1: carry_r <= dp_res_i;
              2'd2: begin
                res_r[47:24] <= dp_res_i[23:0];
                carry_r      <= {24'd0, dp_res_i[47:24]};
              end
              default: res_r[63:48] <= dp_res_i[15:0];
            endcase
            if (!last_pass) pass_r <= pass_r + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_o     = res_r;
  assign type_o    = op_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_bsg_fma_mul_sequencer.sv
// Randomized scoreboard bench for bsg_fma_mul_sequencer with a latency-programmable
// datapath model; two instances (skip on / skip off) share stimulus via a select.
module tb_bsg_fma_mul_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        v_i = 1'b0;
  logic        opcode_i = 1'b0;
  logic [31:0] opA_i = '0;
  logic [31:0] opB_i = '0;
  logic [47:0] opC_i = '0;
  logic        dp_v_i = 1'b0;
  logic [47:0] dp_res_i = '0;
  logic        yumi_i = 1'b0;
  logic        sel = 1'b0;

  logic [1:0]  ready_w, dpv_w, v_w, type_w;
  logic [23:0] dpa_w [2];
  logic [23:0] dpb_w [2];
  logic [47:0] dpc_w [2];
  logic [63:0] res_w [2];
  logic [1:0]  st_w  [2];

  logic        ready_o, dp_v_o, v_o, type_o;
  logic [23:0] dp_a_o, dp_b_o;
  logic [47:0] dp_c_o;
  logic [63:0] res_o;

  assign ready_o = ready_w[sel];
  assign dp_v_o  = dpv_w[sel];
  assign v_o     = v_w[sel];
  assign type_o  = type_w[sel];
  assign dp_a_o  = dpa_w[sel];
  assign dp_b_o  = dpb_w[sel];
  assign dp_c_o  = dpc_w[sel];
  assign res_o   = res_w[sel];

  always #5 clk_i = ~clk_i;

  bsg_fma_mul_sequencer #(.skip_zero_high_p(1'b1)) u_skip (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i & ~sel), .ready_o(ready_w[0]),
    .opcode_i(opcode_i), .opA_i(opA_i), .opB_i(opB_i), .opC_i(opC_i),
    .dp_v_o(dpv_w[0]), .dp_a_o(dpa_w[0]), .dp_b_o(dpb_w[0]), .dp_c_o(dpc_w[0]),
    .dp_v_i(dp_v_i & ~sel), .dp_res_i(dp_res_i), .v_o(v_w[0]), .res_o(res_w[0]),
    .type_o(type_w[0]), .yumi_i(yumi_i & ~sel), .state_dbg(st_w[0])
  );

  bsg_fma_mul_sequencer #(.skip_zero_high_p(1'b0)) u_noskip (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i & sel), .ready_o(ready_w[1]),
    .opcode_i(opcode_i), .opA_i(opA_i), .opB_i(opB_i), .opC_i(opC_i),
    .dp_v_o(dpv_w[1]), .dp_a_o(dpa_w[1]), .dp_b_o(dpb_w[1]), .dp_c_o(dpc_w[1]),
    .dp_v_i(dp_v_i & sel), .dp_res_i(dp_res_i), .v_o(v_w[1]), .res_o(res_w[1]),
    .type_o(type_w[1]), .yumi_i(yumi_i & sel), .state_dbg(st_w[1])
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  logic hold_yumi = 1'b0;
  logic take_now = 1'b0;

  logic [64:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_pass_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the arithmetic result and pass count straight from the operation rules.
  function automatic logic [64:0] model(input logic op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [47:0] c);
    logic [63:0] r;
    if (op) begin
      r = 64'(a[23:0]) * 64'(b[23:0]) + 64'(c);
      r[63:48] = 16'd0;
    end else begin
      r = 64'(a) * 64'(b);
    end
    return {op, r};
  endfunction

  function automatic int npass(input logic op, input logic [31:0] a, input logic [31:0] b,
                               input logic skip);
    if (op) return 1;
    if (skip && a[31:24] == 8'd0 && b[31:24] == 8'd0) return 1;
    return 4;
  endfunction

  // Datapath model: answers x*y+c exactly lat cycles after each issue strobe.
  logic        dp_busy = 1'b0;
  int          dp_cnt_down = 0;
  logic [47:0] dp_pend = '0;
  always @(posedge clk_i) begin
    #1;
    dp_v_i = 1'b0;
    if (dp_busy) begin
      dp_cnt_down--;
      if (dp_cnt_down == 0) begin
        dp_v_i   = 1'b1;
        dp_res_i = dp_pend;
        dp_busy  = 1'b0;
      end
    end
    if (dp_v_o) begin
      dp_busy     = 1'b1;
      dp_cnt_down = lat;
      dp_pend     = 48'(48'(dp_a_o) * 48'(dp_b_o) + dp_c_o);
    end
  end

  // Consumer: random takes, or a scripted take while backpressure is held.
  always @(posedge clk_i) begin
    #1;
    yumi_i = v_o && (hold_yumi ? take_now : ($urandom_range(0, 2) == 0));
  end

  // Monitor: latency and pass count at the rising v_o, hold and value checks after.
  logic        prev_v = 1'b0;
  int          dp_cnt = 0;
  logic [63:0] held = '0;
  logic [64:0] e;
  always @(negedge clk_i) begin
    if (!reset_i) begin
      dp_cnt = 0;
      prev_v = 1'b0;
    end else begin
      if (dp_v_o) dp_cnt++;
      if (v_o && !prev_v) begin
        if (exp_cyc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_v: v_o rose with no request outstanding (cycle %0d)", cyc);
        end else begin
          check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
          check("passes", 64'(dp_cnt), 64'(exp_pass_q.pop_front()));
        end
        dp_cnt = 0;
        held = res_o;
      end else if (v_o) begin
        check("hold", res_o, held);
      end
      if (v_o && yumi_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res", res_o, e[63:0]);
        check("type", 64'(type_o), 64'(e[64]));
      end
      prev_v = v_o;
    end
  end

  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic [47:0] c);
    int n;
    v_i = 1'b1; opcode_i = op; opA_i = a; opB_i = b; opC_i = c;
    n = 0;
    while (!ready_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL accept_timeout: ready_o stayed %0b", ready_o);
    end
    exp_q.push_back(model(op, a, b, c));
    exp_pass_q.push_back(npass(op, a, b, ~sel));
    exp_cyc_q.push_back(cyc + npass(op, a, b, ~sel) * (lat + 1) + 1);
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_q.size());
      exp_q.delete(); exp_cyc_q.delete(); exp_pass_q.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    check({tag, "_dp_v"}, 64'(dp_v_o), 64'd0);
    check({tag, "_v"}, 64'(v_o), 64'd0);
    check({tag, "_res"}, res_o, 64'd0);
    check({tag, "_type"}, 64'(type_o), 64'd0);
    check({tag, "_dp_a"}, 64'(dp_a_o), 64'd0);
    check({tag, "_dp_b"}, 64'(dp_b_o), 64'd0);
    check({tag, "_dp_c"}, 64'(dp_c_o), 64'd0);
  endtask

  task automatic run_one(input logic s, input int l, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [47:0] c);
    sel = s;
    lat = l;
    send(op, a, b, c);
    drain();
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    logic [47:0] c;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("por");
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(negedge clk_i);

    run_one(1'b0, 2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'd0);
    run_one(1'b0, 1, 1'b0, 32'h0100_0000, 32'h0100_0000, 48'd0);
    run_one(1'b0, 2, 1'b0, 32'h0000_1000, 32'h0000_0010, 48'h123);
    run_one(1'b1, 2, 1'b0, 32'h0000_1000, 32'h0000_0010, 48'h123);
    run_one(1'b0, 3, 1'b1, 32'h0000_0003, 32'h0000_0005, 48'h7);
    run_one(1'b1, 1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF);

    // Reset in the WAIT of pass 2; the in-flight datapath answer lands after release.
    sel = 1'b0;
    lat = 2;
    send(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 48'd0);
    repeat (7) @(posedge clk_i);
    #1 reset_i = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete(); exp_cyc_q.delete(); exp_pass_q.delete();
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("late_dp_v", 64'(v_o), 64'd0);
      check("late_ready", 64'(ready_o), 64'd1);
    end
    run_one(1'b0, 2, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 48'd0);

    // Backpressure with the next request already waiting on v_i.
    hold_yumi = 1'b1;
    take_now  = 1'b0;
    lat = 2;
    send(1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 48'd0);
    n = 0;
    while (!v_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("bp_v_seen", 64'(v_o), 64'd1);
    v_i = 1'b1; opcode_i = 1'b1; opA_i = 32'h0000_0102; opB_i = 32'h0000_0304; opC_i = 48'h55;
    repeat (10) begin
      @(negedge clk_i);
      check("bp_ready", 64'(ready_o), 64'd0);
      check("bp_dp_v", 64'(dp_v_o), 64'd0);
      check("bp_v", 64'(v_o), 64'd1);
    end
    take_now = 1'b1;
    @(negedge clk_i);
    take_now = 1'b0;
    check("bp_ready_at_yumi", 64'(ready_o), 64'd0);
    @(negedge clk_i);
    check("bp_ready_after_yumi", 64'(ready_o), 64'd1);
    send(1'b1, 32'h0000_0102, 32'h0000_0304, 48'h55);
    hold_yumi = 1'b0;
    drain();

    for (int g = 0; g < 10; g++) begin
      sel = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 4);
      for (int k = 0; k < 5; k++) begin
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 2) == 0) a[31:24] = 8'd0;
        if ($urandom_range(0, 2) == 0) b[31:24] = 8'd0;
        c = {16'($urandom), 32'($urandom)};
        send(1'($urandom_range(0, 1)), a, b, c);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
